line_clear_executor: RTL and testbench

LINE_CLEAR_EXECUTOR -- requirements
Module: line_clear_executor

---
 rtl/tetris_pkg.sv | 12 +
 rtl/line_clear_executor.sv | 138 +++++++++++++
 tb/tb_line_clear_executor.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared types for the playfield logic.
package tetris_pkg;

  typedef enum logic [2:0] {
    eIDLE,
    eREAD,
    eEVAL,
    eFILL,
    eDONE
  } line_clear_state_e;

endpackage

// File: rtl/line_clear_executor.sv
// Removes full lines from a playfield memory: scans bottom-up, compacts the surviving
// lines downward, then zero-fills the vacated lines at the top.
module line_clear_executor
  import tetris_pkg::*;
#(
  parameter int unsigned word_width_p = 10,
  parameter int unsigned size_p       = 20
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          start_i,
  output logic                          ready_o,
  output logic                          done_o,
  output logic [$clog2(size_p+1)-1:0]   lines_cleared_o,
  output logic [$clog2(size_p)-1:0]     read_line_addr_o,
  output logic                          v_r_o,
  input  logic [word_width_p-1:0]       read_line_data_i,
  output logic [$clog2(size_p)-1:0]     write_addr_o,
  output logic [word_width_p-1:0]       write_data_o,
  output logic                          v_w_o,
  input  logic                          mem_ready_i
);

  localparam int unsigned AddrW = $clog2(size_p);
  localparam int unsigned CntW  = $clog2(size_p + 1);
  localparam logic [AddrW-1:0] LastLine = AddrW'(size_p - 1);

  line_clear_state_e state_q, state_d;
  logic [AddrW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]         count_q, count_d, lines_cleared_q, lines_cleared_d;
  logic [word_width_p-1:0] line_q, cur_line;
  logic                    eval_first_q;
  logic                    line_full;
  logic                    advance;

  // Read data is only guaranteed on the first eEVAL cycle; a write stall replays the copy.
  assign cur_line        = eval_first_q ? read_line_data_i : line_q;
  assign line_full       = &cur_line;
  assign lines_cleared_o = lines_cleared_q;

  always_comb begin
    state_d          = state_q;
    rd_ptr_d         = rd_ptr_q;
    wr_ptr_d         = wr_ptr_q;
    count_d          = count_q;
    lines_cleared_d  = lines_cleared_q;
    advance          = 1'b1;
    ready_o          = 1'b0;
    done_o           = 1'b0;
    v_r_o            = 1'b0;
    v_w_o            = 1'b0;
    read_line_addr_o = rd_ptr_q;
    write_addr_o     = wr_ptr_q;
    write_data_o     = '0;

    unique case (state_q)
      eIDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          rd_ptr_d = LastLine;
          wr_ptr_d = LastLine;
          count_d  = '0;
          state_d  = eREAD;
        end
      end
      eREAD: begin
        if (mem_ready_i) begin
          v_r_o   = 1'b1;
          state_d = eEVAL;
        end
      end
      eEVAL: begin
        if (line_full) begin
          count_d = count_q + 1'b1;
        end else begin
          if (wr_ptr_q != rd_ptr_q) begin
            write_data_o = cur_line;
            if (mem_ready_i) v_w_o = 1'b1;
            else             advance = 1'b0;
          end
          // Saturate at 0: only reached with nothing cleared, where eFILL is skipped.
          if (advance && wr_ptr_q != '0) wr_ptr_d = wr_ptr_q - 1'b1;
        end
        if (advance) begin
          if (rd_ptr_q == '0) begin
            if (count_d == '0) begin
              lines_cleared_d = count_d;
              state_d         = eDONE;
            end else begin
              state_d = eFILL;
            end
          end else begin
            rd_ptr_d = rd_ptr_q - 1'b1;
            state_d  = eREAD;
          end
        end
      end
      eFILL: begin
        if (mem_ready_i) begin
          v_w_o = 1'b1;
          if (wr_ptr_q == '0) begin
            lines_cleared_d = count_q;
            state_d         = eDONE;
          end else begin
            wr_ptr_d = wr_ptr_q - 1'b1;
          end
        end
      end
      eDONE: begin
        done_o  = 1'b1;
        state_d = eIDLE;
      end
      default: state_d = eIDLE;
    endcase
  end

  // The result register is loaded on entry to eDONE so it is valid alongside done_o.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q         <= eIDLE;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      lines_cleared_q <= '0;
      line_q          <= '0;
      eval_first_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      lines_cleared_q <= lines_cleared_d;
      eval_first_q    <= (state_q == eREAD) && mem_ready_i;
      if (state_q == eEVAL) line_q <= cur_line;
    end
  end

endmodule

// File: tb/tb_line_clear_executor.sv
// Directed bench for line_clear_executor with a behavioural line memory.
module tb_line_clear_executor;

  localparam int W = 10;
  localparam int N = 20;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          start_i;
  logic          ready_o;
  logic          done_o;
  logic [4:0]    lines_cleared_o;
  logic [4:0]    read_line_addr_o;
  logic          v_r_o;
  logic [W-1:0]  read_line_data_i;
  logic [4:0]    write_addr_o;
  logic [W-1:0]  write_data_o;
  logic          v_w_o;
  logic          mem_ready_i;

  logic [W-1:0]  mem      [N];
  logic [W-1:0]  load_img [N];
  logic [W-1:0]  exp_img  [N];
  logic          load_en;
  int            wr_cnt   = 0;
  int            viol_cnt = 0;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc;
  int            w0;

  line_clear_executor #(
    .word_width_p (W),
    .size_p       (N)
  ) dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .start_i          (start_i),
    .ready_o          (ready_o),
    .done_o           (done_o),
    .lines_cleared_o  (lines_cleared_o),
    .read_line_addr_o (read_line_addr_o),
    .v_r_o            (v_r_o),
    .read_line_data_i (read_line_data_i),
    .write_addr_o     (write_addr_o),
    .write_data_o     (write_data_o),
    .v_w_o            (v_w_o),
    .mem_ready_i      (mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Line memory: one-cycle read latency, write on strobe, bench preload port.
  always @(posedge clk_i) begin
    if (load_en) begin
      for (int i = 0; i < N; i++) mem[i] <= load_img[i];
    end else if (v_w_o) begin
      mem[write_addr_o] <= write_data_o;
      wr_cnt <= wr_cnt + 1;
    end
    if (v_r_o) read_line_data_i <= mem[read_line_addr_o];
  end

  always @(negedge clk_i) begin
    if (reset_n_i && (((v_r_o || v_w_o) && !mem_ready_i) || (v_r_o && v_w_o)))
      viol_cnt <= viol_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_mem();
    load_en = 1'b1;
    @(posedge clk_i); #1;
    load_en = 1'b0;
  endtask

  task automatic check_mem(input string t);
    for (int i = 0; i < N; i++) check($sformatf("%s_line%0d", t, i), mem[i], exp_img[i]);
  endtask

  // Starts a pass and returns the cycle (1 = first cycle after the start edge) of done_o.
  task automatic run_pass(input bit stall, input bit hold_start, output int cycles);
    int c;
    bit seen;
    check("ready_before_start", ready_o, 1);
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = hold_start;
    c = 1;
    seen = 1'b0;
    while (!seen && c <= 200) begin
      mem_ready_i = stall ? !(c >= 10 && c < 26) : 1'b1;
      @(negedge clk_i);
      if (done_o) seen = 1'b1;
      else begin
        @(posedge clk_i); #1;
        c++;
      end
    end
    check("done_pulse", done_o, 1);
    cycles = c;
    mem_ready_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("done_one_cycle", done_o, 0);
    check("ready_after_done", ready_o, 1);
  endtask

  task automatic set_image_b();
    for (int i = 0; i < N - 1; i++) load_img[i] = W'(i);
    load_img[N-1] = 10'h3FF;
    exp_img[0] = '0;
    for (int k = 1; k < N; k++) exp_img[k] = W'(k - 1);
  endtask

  task automatic set_image_c();
    for (int i = 0; i < N; i++) begin
      load_img[i] = '0;
      exp_img[i]  = '0;
    end
    load_img[16] = 10'h3FF;
    load_img[17] = 10'h155;
    load_img[18] = 10'h3FF;
    load_img[19] = 10'h0F0;
    exp_img[18]  = 10'h155;
    exp_img[19]  = 10'h0F0;
  endtask

  initial begin
    reset_n_i   = 1'b0;
    start_i     = 1'b0;
    mem_ready_i = 1'b1;
    load_en     = 1'b0;
    #2;
    check("rst_ready", ready_o, 1);
    check("rst_done", done_o, 0);
    check("rst_lines_cleared", lines_cleared_o, 0);
    check("rst_v_r", v_r_o, 0);
    check("rst_v_w", v_w_o, 0);
    check("rst_raddr", read_line_addr_o, 0);
    check("rst_waddr", write_addr_o, 0);
    check("rst_wdata", write_data_o, 0);
    @(posedge clk_i); @(posedge clk_i); #1;
    reset_n_i = 1'b1;

    // Bottom line full, rest empty.
    for (int i = 0; i < N; i++) begin
      load_img[i] = '0;
      exp_img[i]  = '0;
    end
    load_img[N-1] = 10'h3FF;
    load_mem();
    w0 = wr_cnt;
    run_pass(1'b0, 1'b0, cyc);
    check("a_cleared", lines_cleared_o, 1);
    check("a_writes", wr_cnt - w0, 20);
    check_mem("a");

    // Bottom line full, distinct contents above shift down by one.
    set_image_b();
    load_mem();
    run_pass(1'b0, 1'b0, cyc);
    check("b_cleared", lines_cleared_o, 1);
    check("b_cycles", cyc, 42);
    check_mem("b");

    // Two non-adjacent full lines; start held high throughout the pass.
    set_image_c();
    load_mem();
    w0 = wr_cnt;
    run_pass(1'b0, 1'b1, cyc);
    check("c_cleared", lines_cleared_o, 2);
    check("c_writes", wr_cnt - w0, 19);
    check_mem("c");

    // No full lines: memory untouched, no writes.
    for (int i = 0; i < N; i++) begin
      load_img[i] = W'(i) ^ 10'h2AA;
      exp_img[i]  = W'(i) ^ 10'h2AA;
    end
    load_mem();
    w0 = wr_cnt;
    run_pass(1'b0, 1'b0, cyc);
    check("d_cleared", lines_cleared_o, 0);
    check("d_writes", wr_cnt - w0, 0);
    check("d_cycles", cyc, 2 * N + 1);
    check_mem("d");

    // All lines full.
    for (int i = 0; i < N; i++) begin
      load_img[i] = 10'h3FF;
      exp_img[i]  = '0;
    end
    load_mem();
    w0 = wr_cnt;
    run_pass(1'b0, 1'b0, cyc);
    check("e_cleared", lines_cleared_o, N);
    check("e_writes", wr_cnt - w0, N);
    check("e_cycles", cyc, 3 * N + 1);
    check_mem("e");

    // Image b again with a 16-cycle memory-busy window mid-pass.
    set_image_b();
    load_mem();
    run_pass(1'b1, 1'b0, cyc);
    check("f_cleared", lines_cleared_o, 1);
    check("f_cycles", cyc, 42 + 16);
    check("f_strobe_rules", viol_cnt, 0);
    check_mem("f");

    // Reset while zero-filling, then a normal pass.
    for (int i = 0; i < N; i++) load_img[i] = 10'h3FF;
    load_mem();
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int c = 0; c < 100 && !v_w_o; c++) begin
      @(negedge clk_i);
      if (!v_w_o) begin
        @(posedge clk_i); #1;
      end
    end
    check("g_fill_reached", v_w_o, 1);
    reset_n_i = 1'b0;
    #1;
    check("g_rst_ready", ready_o, 1);
    check("g_rst_v_w", v_w_o, 0);
    check("g_rst_v_r", v_r_o, 0);
    check("g_rst_done", done_o, 0);
    check("g_rst_cleared", lines_cleared_o, 0);
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    set_image_c();
    load_mem();
    run_pass(1'b0, 1'b0, cyc);
    check("g_cleared", lines_cleared_o, 2);
    check_mem("g");
    check("strobe_rules", viol_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
